// File: rtl/spp_pkg.sv
// spp_pkg: shared FP16 constants, FSM encoding and the max-pool ordering key.
// Used by every file of the SPP max-pool block.
package spp_pkg;

    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Monotonic integer image of an FP16 value; -0 sorts just below +0.
    function automatic logic [15:0] fp16_key(input logic [15:0] x);
        return x[15] ? ~x : (x | 16'h8000);
    endfunction

    function automatic logic fp16_is_nan(input logic [15:0] x);
        return (&x[14:10]) && (|x[9:0]);
    endfunction

endpackage

// File: rtl/spp_maxpool_frame_if.sv
// spp_maxpool_frame_if: pixel stream in, window-maximum stream out, busy flag.
// master = stream source/sink side, slave = the max-pool block.
interface spp_maxpool_frame_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/fp16_max2.sv
// fp16_max2: combinational FP16 maximum by ordering key, keeping 'a' on a tie.
// With SPP_MAXPOOL_NAN_EN defined any NaN operand yields the quiet NaN.
module fp16_max2
    import spp_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [15:0] ordered;

    assign ordered = (fp16_key(b) > fp16_key(a)) ? b : a;

`ifdef SPP_MAXPOOL_NAN_EN
    assign y = (fp16_is_nan(a) || fp16_is_nan(b)) ? FP16_QNAN : ordered;
`else
    assign y = ordered;
`endif

endmodule

// File: rtl/spp_maxpool_frame.sv
// spp_maxpool_frame: stride-1 same-padded KxK FP16 max-pool over one buffered plane.
// Optional SPP_MAXPOOL_NAN_EN: any NaN in a window forces the quiet-NaN output.
module spp_maxpool_frame
    import spp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 13,
    parameter int W          = 13,
    parameter int K          = 5
) (
    input logic              clk,
    input logic              reset,
    spp_maxpool_frame_if.slave bus
);

    localparam int P  = (K - 1) / 2;
    localparam int N  = H * W;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = $clog2(H + W + 2 * K) + 2;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] buf_q [N];
    logic [AW-1:0]         wr_idx;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [KW-1:0]         dr;
    logic [KW-1:0]         dc;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;

    logic signed [SW-1:0]  pr;
    logic signed [SW-1:0]  pc;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] elem;
    logic [DATA_WIDTH-1:0] cand;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] result;
    logic                  inb;
    logic                  in_fire;
    logic                  wr_last;
    logic                  k_row_end;
    logic                  win_last;
    logic                  row_end;
    logic                  pix_last;

    assign bus.in_ready  = (state_q == LOAD) && !reset;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.busy      = (state_q != LOAD);
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign wr_last   = (wr_idx == AW'(N - 1));
    assign k_row_end = (dc == KW'(K - 1));
    assign win_last  = k_row_end && (dr == KW'(K - 1));
    assign row_end   = (col == CW'(W - 1));
    assign pix_last  = row_end && (row == RW'(H - 1));

    // Window position relative to the plane; negative means above/left of it.
    assign pr = SW'(row) + SW'(dr) - SW'(P);
    assign pc = SW'(col) + SW'(dc) - SW'(P);

    assign inb = !pr[SW-1] && !pc[SW-1]
              && (pr < SW'(H)) && (pc < SW'(W));

    assign rd_idx = AW'(pr) * AW'(W) + AW'(pc);
    assign elem   = inb ? buf_q[rd_idx] : FP16_NEG_INF;

    fp16_max2 u_max (
        .a (acc),
        .b (elem),
        .y (cand)
    );

    assign acc_next = inb ? cand : acc;

`ifdef SPP_MAXPOOL_NAN_EN
    logic nan_q;
    logic nan_hit;

    assign nan_hit = nan_q || (inb && fp16_is_nan(elem));
    assign result  = nan_hit ? FP16_QNAN : acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nan_q <= 1'b0;
        end else if (state_q == SCAN) begin
            nan_q <= win_last ? 1'b0 : nan_hit;
        end
    end
`else
    assign result = acc_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (in_fire && wr_last) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (win_last) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    state_d = pix_last ? LOAD : SCAN;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Plane storage needs no reset: every word is rewritten before SCAN.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[wr_idx] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx     <= '0;
            row        <= '0;
            col        <= '0;
            dr         <= '0;
            dc         <= '0;
            acc        <= FP16_NEG_INF;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
                    end
                end
                SCAN: begin
                    if (win_last) begin
                        dr         <= '0;
                        dc         <= '0;
                        acc        <= FP16_NEG_INF;
                        out_data_q <= result;
                        out_last_q <= pix_last;
                    end else begin
                        acc <= acc_next;
                        if (k_row_end) begin
                            dc <= '0;
                            dr <= dr + 1'b1;
                        end else begin
                            dc <= dc + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (row_end) begin
                            col <= '0;
                            row <= pix_last ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spp_maxpool_frame.sv
// tb_spp_maxpool_frame: vector table, corner sequences and random frames
// against a window-maximum reference model, over four plane/window shapes.
module tb_spp_maxpool_frame;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int          sel;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic        o_in_ready;
    logic        o_out_valid;
    logic        o_out_last;
    logic        o_busy;
    logic [15:0] o_out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    localparam int HH[4] = '{3, 1, 4, 3};
    localparam int WW[4] = '{3, 1, 5, 3};
    localparam int KK[4] = '{3, 5, 5, 1};

    spp_maxpool_frame_if b0 ();
    spp_maxpool_frame_if b1 ();
    spp_maxpool_frame_if b2 ();
    spp_maxpool_frame_if b3 ();

    assign b0.in_valid  = in_valid && (sel == 0);
    assign b1.in_valid  = in_valid && (sel == 1);
    assign b2.in_valid  = in_valid && (sel == 2);
    assign b3.in_valid  = in_valid && (sel == 3);
    assign b0.out_ready = out_ready && (sel == 0);
    assign b1.out_ready = out_ready && (sel == 1);
    assign b2.out_ready = out_ready && (sel == 2);
    assign b3.out_ready = out_ready && (sel == 3);
    assign b0.in_data   = in_data;
    assign b1.in_data   = in_data;
    assign b2.in_data   = in_data;
    assign b3.in_data   = in_data;

    always_comb begin
        o_in_ready  = b0.in_ready;
        o_out_valid = b0.out_valid;
        o_out_last  = b0.out_last;
        o_out_data  = b0.out_data;
        o_busy      = b0.busy;
        case (sel)
            1: begin
                o_in_ready  = b1.in_ready;
                o_out_valid = b1.out_valid;
                o_out_last  = b1.out_last;
                o_out_data  = b1.out_data;
                o_busy      = b1.busy;
            end
            2: begin
                o_in_ready  = b2.in_ready;
                o_out_valid = b2.out_valid;
                o_out_last  = b2.out_last;
                o_out_data  = b2.out_data;
                o_busy      = b2.busy;
            end
            3: begin
                o_in_ready  = b3.in_ready;
                o_out_valid = b3.out_valid;
                o_out_last  = b3.out_last;
                o_out_data  = b3.out_data;
                o_busy      = b3.busy;
            end
            default: ;
        endcase
    end

    spp_maxpool_frame #(.H(3), .W(3), .K(3)) d0 (.clk(clk), .reset(reset), .bus(b0));
    spp_maxpool_frame #(.H(1), .W(1), .K(5)) d1 (.clk(clk), .reset(reset), .bus(b1));
    spp_maxpool_frame #(.H(4), .W(5), .K(5)) d2 (.clk(clk), .reset(reset), .bus(b2));
    spp_maxpool_frame #(.H(3), .W(3), .K(1)) d3 (.clk(clk), .reset(reset), .bus(b3));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] key(input logic [15:0] x);
        return x[15] ? ~x : {1'b1, x[14:0]};
    endfunction

    function automatic bit is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
    endfunction

    // Reference: largest key among in-plane pixels of the KxK neighbourhood.
    task automatic model(input int s, input logic [15:0] px[$], output logic [15:0] ex[$]);
        int h = HH[s];
        int w = WW[s];
        int p = (KK[s] - 1) / 2;
        ex = {};
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                logic [15:0] best = 16'hFC00;
                bit nan = 1'b0;
                for (int i = r - p; i <= r + p; i++) begin
                    for (int j = c - p; j <= c + p; j++) begin
                        if (i >= 0 && i < h && j >= 0 && j < w) begin
                            if (is_nan(px[i * w + j])) nan = 1'b1;
                            if (key(px[i * w + j]) > key(best)) best = px[i * w + j];
                        end
                    end
                end
`ifdef SPP_MAXPOOL_NAN_EN
                if (nan) best = 16'h7E00;
`else
                if (nan && best == 16'h0) best = 16'h0;
`endif
                ex.push_back(best);
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] px[$], input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < px.size()) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                chk("send_timeout", 32'(i), 32'(px.size()));
                break;
            end
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = px[i];
                if (o_in_ready) i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv_frame(input int n, input int mode, output logic [15:0] q[$]);
        int got_n = 0;
        int guard = 0;
        q = {};
        hs_cyc = {};
        while (got_n < n) begin
            @(negedge clk);
            guard++;
            if (guard > 400 * n + 400) begin
                chk("recv_timeout", 32'(got_n), 32'(n));
                break;
            end
            out_ready = (mode == 0) ? 1'b1 : ($urandom_range(2) != 0);
            if (o_out_valid && out_ready) begin
                q.push_back(o_out_data);
                hs_cyc.push_back(cyc);
                chk($sformatf("out_last[%0d]", got_n), 32'(o_out_last), 32'(got_n == n - 1));
                got_n++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_last", 32'(o_in_ready), 32'd1);
    endtask

    task automatic cmp_frame(input string name, input logic [15:0] got[$], input logic [15:0] ex[$]);
        chk({name, "_count"}, 32'(got.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(ex[i]));
        end
    endtask

    task automatic wait_valid(input string name);
        int guard = 0;
        while (!o_out_valid && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk(name, 32'(o_out_valid), 32'd1);
    endtask

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] pin [9];
        logic [15:0] pexp[9];
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[6];
        logic [15:0] px[$];
        logic [15:0] q[$];
        logic [15:0] ex[$];
        logic [15:0] t2[$];
        logic [15:0] t2e[$];
        logic [15:0] sp[7];
        logic [15:0] hd;
        logic        hl;
        int          n;
        int          s;

        t2  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                16'h4600, 16'h4700, 16'h4800, 16'h4880};
        t2e = '{16'h4500, 16'h4600, 16'h4600, 16'h4800, 16'h4880,
                16'h4880, 16'h4800, 16'h4880, 16'h4880};

        vt[0].name = "ramp";
        vt[0].sel  = 0;
        vt[0].pin  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                       16'h4600, 16'h4700, 16'h4800, 16'h4880};
        vt[0].pexp = '{16'h4500, 16'h4600, 16'h4600, 16'h4800, 16'h4880,
                       16'h4880, 16'h4800, 16'h4880, 16'h4880};
        vt[1].name = "neg_center";
        vt[1].sel  = 0;
        vt[1].pin  = '{16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hB800,
                       16'hC000, 16'hC000, 16'hC000, 16'hC000};
        vt[1].pexp = '{default: 16'hB800};
        vt[2].name = "nan_center";
        vt[2].sel  = 0;
        vt[2].pin  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h7C01,
                       16'h4600, 16'h4700, 16'h4800, 16'h4880};
`ifdef SPP_MAXPOOL_NAN_EN
        vt[2].pexp = '{default: 16'h7E00};
`else
        vt[2].pexp = '{default: 16'h7C01};
`endif
        vt[3].name = "signed_zero";
        vt[3].sel  = 0;
        vt[3].pin  = '{16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                       16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vt[3].pexp = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000,
                       16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vt[4].name = "k1_pass";
        vt[4].sel  = 3;
        vt[4].pin  = '{16'h1234, 16'hFC00, 16'h7C00, 16'h8000, 16'h0000,
                       16'hC000, 16'h3C00, 16'hABCD, 16'h7BFF};
        vt[4].pexp = vt[4].pin;
        vt[5].name = "all_neg_inf";
        vt[5].sel  = 0;
        vt[5].pin  = '{default: 16'hFC00};
        vt[5].pexp = '{default: 16'hFC00};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'h0;
        sel       = 0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(o_in_ready), 32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_out_data", 32'(o_out_data), 32'd0);
        chk("rst_out_last", 32'(o_out_last), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("load_in_ready", 32'(o_in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            sel = vt[v].sel;
            px  = {};
            ex  = {};
            for (int i = 0; i < 9; i++) begin
                px.push_back(vt[v].pin[i]);
                ex.push_back(vt[v].pexp[i]);
            end
            send_frame(px, 1'b0);
            recv_frame(9, 0, q);
            cmp_frame(vt[v].name, q, ex);
            if (hs_cyc.size() >= 2)
                chk({vt[v].name, "_period"}, 32'(hs_cyc[1] - hs_cyc[0]),
                    32'(KK[vt[v].sel] * KK[vt[v].sel] + 1));
        end

        // Single pixel plane with a window larger than the plane.
        sel = 1;
        px  = '{16'h3C00};
        send_frame(px, 1'b0);
        n = 1;
        while (!o_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("k5_1x1_latency", 32'(n), 32'd26);
        recv_frame(1, 0, q);
        ex = '{16'h3C00};
        cmp_frame("k5_1x1", q, ex);

        // Downstream stall in EMIT holds the output stable.
        sel = 0;
        send_frame(t2, 1'b0);
        wait_valid("stall_valid");
        hd = o_out_data;
        hl = o_out_last;
        chk("stall_first", 32'(hd), 32'(t2e[0]));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", 32'(o_out_valid), 32'd1);
            chk("stall_hold_data", 32'(o_out_data), 32'(hd));
            chk("stall_hold_last", 32'(o_out_last), 32'(hl));
            chk("stall_in_ready", 32'(o_in_ready), 32'd0);
        end
        recv_frame(9, 0, q);
        cmp_frame("stall", q, t2e);

        // Reset in the middle of SCAN, then a clean frame.
        send_frame(t2, 1'b0);
        wait_valid("mid_valid");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(o_out_data), 32'd0);
        chk("mid_rst_out_last", 32'(o_out_last), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_in_ready", 32'(o_in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(o_in_ready), 32'd1);
        send_frame(t2, 1'b0);
        recv_frame(9, 0, q);
        cmp_frame("post_rst", q, t2e);

        sp = '{16'h7C00, 16'hFC00, 16'h0000, 16'h8000, 16'h7E00, 16'h7C01, 16'hFE00};
        for (int f = 0; f < 9; f++) begin
            s   = (f % 3 == 0) ? 2 : ((f % 3 == 1) ? 0 : 3);
            sel = s;
            px  = {};
            for (int i = 0; i < HH[s] * WW[s]; i++) begin
                if ($urandom_range(5) == 0) px.push_back(sp[$urandom_range(6)]);
                else px.push_back(16'($urandom()));
            end
            model(s, px, ex);
            send_frame(px, 1'b1);
            recv_frame(HH[s] * WW[s], 1, q);
            cmp_frame($sformatf("rand%0d", f), q, ex);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
